// File: rtl/spi_w25q_stream_fetch_pkg.sv
// Shared types and constants for the W25Q sequential burst fetcher.
// Holds the FSM state encoding, bus widths, address step and the FIFO entry layout.
// Pure declarations; no logic, no latency, no backpressure.
package spi_w25q_stream_fetch_pkg;

    localparam int SPI_ADDR_W = 24;
    localparam int SPI_WORD_W = 32;
    localparam logic [SPI_ADDR_W-1:0] ADDR_STEP = 24'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_HI    = 3'd2,
        ST_WAIT_LO    = 3'd3,
        ST_DRAIN      = 3'd4,
        ST_ABORT_WAIT = 3'd5
    } state_e;

    // FIFO entry: data word plus end-of-burst marker (33 bits).
    typedef struct packed {
        logic                  last;
        logic [SPI_WORD_W-1:0] data;
    } fifo_word_t;

    // Next word address; the 24-bit width makes 0xFFFFFC roll over to 0x000000.
    function automatic logic [SPI_ADDR_W-1:0] addr_next(input logic [SPI_ADDR_W-1:0] a);
        return a + ADDR_STEP;
    endfunction

endpackage

// File: rtl/spi_w25q_stream_fetch_if.sv
// Command and output-stream bundle of the burst fetcher.
// master = loader/consumer side, slave = the fetcher itself.
// Signals only; the valid/ready rules live in the fetcher.
interface spi_w25q_stream_fetch_if
    import spi_w25q_stream_fetch_pkg::*;
#(
    parameter int LEN_W = 16
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [SPI_ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]      cmd_len;

    logic                  out_valid;
    logic                  out_ready;
    logic [SPI_WORD_W-1:0] out_data;
    logic                  out_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_len, out_ready,
        input  cmd_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, out_ready,
        output cmd_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/spi_w25q_stream_fetch_fifo.sv
// Small synchronous FIFO with flush, used as the fetcher's output buffer.
// Head visible the cycle after a push into an empty FIFO; no bypass path.
// Push while full is taken only if a pop happens on the same edge; flush wins over push/pop.
module spi_w25q_stream_fetch_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       head_dat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, the consumer gates on empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/spi_w25q_stream_fetch.sv
// Burst reader: one spi_w25q_read_32b transaction per word, auto-incrementing address, into an output FIFO.
// First word appears one cycle after the reader drops busy; each later word paces with the reader.
// Reads are issued only while FIFO occupancy + in-flight < FIFO_DEPTH, so out_ready=0 stalls the reader side.
module spi_w25q_stream_fetch
    import spi_w25q_stream_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_w25q_stream_fetch_if.slave bus,
    input  logic                   abort_i,
    output logic                   active_o,
    output logic                   rd_start_o,
    output logic [SPI_ADDR_W-1:0]  rd_addr_o,
    input  logic                   rd_busy_i,
    input  logic [SPI_WORD_W-1:0]  rd_data_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e                state_q, state_d;
    logic [SPI_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic                  seen_q, seen_d;
    logic                  active_q, active_d;
    logic                  init_q;

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  room;
    logic                  cmd_fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    fifo_word_t            push_word;
    fifo_word_t            head_word;

    // cmd_ready stays low through reset and for the first cycle after release; abort blocks accept.
    assign bus.cmd_ready = (state_q == ST_IDLE) && init_q && !abort_i;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : head_word.data;
    assign bus.out_last  = fifo_empty ? 1'b0 : head_word.last;
    assign pop           = bus.out_valid && bus.out_ready;

    assign active_o  = active_q;
    assign rd_addr_o = addr_q;
    assign room      = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

    assign push_word.last = (rem_q == LEN_ONE);
    assign push_word.data = rd_data_i;

    spi_w25q_stream_fetch_fifo #(
        .WIDTH ($bits(fifo_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i (push_word),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_dat_o (head_word),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            seen_q     <= 1'b0;
            active_q   <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            seen_q     <= seen_d;
            active_q   <= active_d;
            init_q     <= 1'b1;
        end
    end

    // Next-state, reader handshake, FIFO push/flush and abort sequencing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        inflight_d = inflight_q;
        seen_d     = seen_q;
        active_d   = active_q;
        push       = 1'b0;
        flush      = 1'b0;
        rd_start_o = 1'b0;

        // Burst is complete once the consumer takes the last-tagged word.
        if (pop && head_word.last) begin
            active_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (abort_i) begin
                    flush    = 1'b1;
                    active_d = 1'b0;
                end else if (cmd_fire) begin
                    addr_d = bus.cmd_addr;
                    rem_d  = bus.cmd_len;
                    if (bus.cmd_len != '0) begin
                        state_d  = ST_ISSUE;
                        active_d = 1'b1;
                    end
                end
            end

            // rd_start is not driven here, so an abort in this state never touches the reader.
            ST_ISSUE: begin
                if (abort_i) begin
                    flush    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (room) begin
                    inflight_d = 1'b1;
                    state_d    = ST_WAIT_HI;
                end
            end

            ST_WAIT_HI: begin
                rd_start_o = 1'b1;
                if (abort_i) begin
                    flush   = 1'b1;
                    seen_d  = rd_busy_i;
                    state_d = ST_ABORT_WAIT;
                end else if (rd_busy_i) begin
                    state_d = ST_WAIT_LO;
                end
            end

            ST_WAIT_LO: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    seen_d  = 1'b1;
                    state_d = ST_ABORT_WAIT;
                end else if (!rd_busy_i) begin
                    push       = 1'b1;
                    inflight_d = 1'b0;
                    addr_d     = addr_next(addr_q);
                    rem_d      = rem_q - LEN_ONE;
                    state_d    = (rem_q == LEN_ONE) ? ST_DRAIN : ST_ISSUE;
                end
            end

            ST_DRAIN: begin
                if (abort_i) begin
                    flush    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (fifo_empty) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            // The reader cannot be cancelled: keep start up until it reports busy, then let it finish.
            ST_ABORT_WAIT: begin
                rd_start_o = !seen_q;
                if (rd_busy_i) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    flush      = 1'b1;
                    inflight_d = 1'b0;
                    seen_d     = 1'b0;
                    active_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                flush   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_w25q_stream_fetch.sv
// Directed bench for the W25Q burst fetcher with a behavioural read-engine model.
// Expected addresses and words are queued at command time and consumed by monitors.
// Reader model: fixed start-to-busy and busy-duration delays, data derived from address.
module tb_spi_w25q_stream_fetch;

    localparam int BUSY_CYC = 4;

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        active;
    logic        rd_start;
    logic [23:0] rd_addr;
    logic        r_busy;
    logic [31:0] r_data;

    spi_w25q_stream_fetch_if #(.LEN_W(16)) bus ();

    spi_w25q_stream_fetch #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .abort_i    (abort),
        .active_o   (active),
        .rd_start_o (rd_start),
        .rd_addr_o  (rd_addr),
        .rd_busy_i  (r_busy),
        .rd_data_i  (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    int          n_last   = 0;
    logic [32:0] exp_q[$];
    logic [23:0] exp_addr[$];

    function automatic logic [31:0] fdata(input logic [23:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Read-engine model: accepts start when idle, raises busy after 3 cycles, drops it with data later.
    initial begin
        int          phase;
        int          cnt;
        logic [23:0] a;
        phase = 0; cnt = 0; a = '0;
        r_busy = 1'b0; r_data = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                phase = 0;
                r_busy <= 1'b0;
                r_data <= '0;
            end else begin
                case (phase)
                    0: if (rd_start) begin
                        a = rd_addr;
                        n_starts++;
                        if (exp_addr.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL rd_addr: got unexpected read at 0x%0h, expected no read", a);
                        end else begin
                            chk("rd_addr", 64'(a), 64'(exp_addr.pop_front()));
                        end
                        phase = 1; cnt = 2;
                    end
                    1: if (cnt == 0) begin
                        r_busy <= 1'b1; phase = 2; cnt = BUSY_CYC;
                    end else cnt--;
                    default: if (cnt == 0) begin
                        r_busy <= 1'b0; r_data <= fdata(a); phase = 0;
                    end else cnt--;
                endcase
            end
        end
    end

    // Output monitor: any presented word must match the scoreboard head; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL out_word: got 0x%0h, expected no word", {bus.out_last, bus.out_data});
                end else begin
                    chk(bus.out_ready ? "out_word" : "out_word_stalled",
                        64'({bus.out_last, bus.out_data}), 64'(exp_q[0]));
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        if (bus.out_last) n_last++;
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [23:0] a, input logic [15:0] len, input int n_addr, input int n_words);
        bit          fired;
        int          k;
        logic [23:0] t;
        for (int i = 0; i < int'(len); i++) begin
            t = a + 24'(4 * i);
            if (i < n_addr)  exp_addr.push_back(t);
            if (i < n_words) exp_q.push_back({(i == int'(len) - 1), fdata(t)});
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = len;
        fired = 1'b0; k = 0;
        while (!fired && k < 100) begin
            @(negedge clk); fired = bus.cmd_ready;
            @(posedge clk); k++;
        end
        #1 bus.cmd_valid = 1'b0;
        if (!fired) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (k < 3000 && !(exp_q.size() == 0 && !active && bus.cmd_ready)) begin
            @(negedge clk); k++;
        end
        if (k >= 3000) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_words_left"}, 64'(exp_q.size()), 0);
        chk({tag, "_reads_left"}, 64'(exp_addr.size()), 0);
    endtask

    initial begin
        int s0;
        int l0;
        int k;
        bit bad;
        rst_n = 1'b0; abort = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_active", active, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_rd_addr", rd_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("cmd_ready_after_reset", bus.cmd_ready, 1);

        // Plain 3-word burst
        send_cmd(24'h010000, 16'd3, 3, 3);
        @(negedge clk);
        chk("active_after_accept", active, 1);
        chk("cmd_ready_busy", bus.cmd_ready, 0);
        wait_idle("burst3");

        // Address wrap at top of the 24-bit space
        send_cmd(24'hFFFFF8, 16'd4, 4, 4);
        wait_idle("wrap");

        // Consumer stalled: only FIFO_DEPTH reads may be issued
        bus.out_ready = 1'b0;
        s0 = n_starts;
        send_cmd(24'h020000, 16'd8, 8, 8);
        repeat (150) @(negedge clk);
        chk("stall_reads_issued", 64'(n_starts - s0), 4);
        chk("stall_out_valid", bus.out_valid, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        wait_idle("stall");

        // Abort while word 2 is in the reader's busy phase
        bus.out_ready = 1'b0;
        s0 = n_starts;
        send_cmd(24'h000100, 16'd5, 2, 1);
        k = 0;
        while (!(n_starts == s0 + 2 && r_busy) && k < 500) begin
            @(negedge clk); k++;
        end
        if (k >= 500) chk("abort_reach_timeout", 0, 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_cmd_ready_while_busy", bus.cmd_ready, 0);
        chk("abort_reader_busy", r_busy, 1);
        k = 0;
        while (r_busy && k < 100) begin
            @(negedge clk); k++;
        end
        repeat (2) @(negedge clk);
        chk("abort_cmd_ready_after", bus.cmd_ready, 1);
        chk("abort_active", active, 0);
        chk("abort_out_valid_after", bus.out_valid, 0);
        chk("abort_reads", 64'(n_starts - s0), 2);
        chk("abort_reads_left", 64'(exp_addr.size()), 0);
        bus.out_ready = 1'b1;

        // Zero-length command
        s0 = n_starts;
        send_cmd(24'h000200, 16'd0, 0, 0);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rd_start || bus.out_valid || !bus.cmd_ready || active) bad = 1'b1;
        end
        chk("len0_quiet", bad, 0);
        chk("len0_no_read", 64'(n_starts - s0), 0);

        // Reset in the middle of a burst
        s0 = n_starts;
        send_cmd(24'h000300, 16'd6, 6, 6);
        k = 0;
        while (n_starts < s0 + 2 && k < 500) begin
            @(negedge clk); k++;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        exp_q.delete(); exp_addr.delete();
        #1;
        chk("midrst_cmd_ready", bus.cmd_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_active", active, 0);
        chk("midrst_rd_start", rd_start, 0);
        chk("midrst_rd_addr", rd_addr, 0);
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_cmd_ready_after", bus.cmd_ready, 1);

        // Random consumer backpressure over a 16-word burst
        l0 = n_last;
        send_cmd(24'h123450, 16'd16, 16, 16);
        k = 0;
        while (k < 4000 && !(exp_q.size() == 0 && !active && bus.cmd_ready)) begin
            @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1)); k++;
        end
        bus.out_ready = 1'b1;
        wait_idle("random");
        chk("random_single_last", 64'(n_last - l0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
